mpd_io_cfg_bank: RTL and testbench
==================================

MPD_IO_CFG_BANK -- requirements
Module: mpd_io_cfg_bank

Interface
REQ-001 SHALL have parameter NUM_IO, default 8, meaning the number of pad channels (1..32).
REQ-002 SHALL have parameter CFG_DEFAULTS, default 12'h001, meaning the per-channel reset/fallback 12-bit configuration.
REQ-003 SHALL have parameter FABRIC_MASK, default all-ones [NUM_IO-1:0], meaning the channels that fabric may reconfigure.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; port order clk, resetn.
REQ-005 clk  input  1  block clock.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 fabric_done  input  1  fabric configured; gates fabric configuration.
REQ-008 wr_valid / wr_ready  input / output  1 / 1  shadow-write handshake.
REQ-009 wr_idx  input  $clog2(NUM_IO) (min 1)  target channel.
REQ-010 wr_data  input  12  configuration word, with the bit layout of REQ-020.
REQ-011 cfg_commit  input  1  request to copy shadow to active.
REQ-012 cfg_applied  output  1  one-cycle pulse after a copy.
REQ-013 cfg_err  output  1  sticky out-of-range write flag.
REQ-014 pad_gpio_slow_sel, pad_gpio_vtrip_sel, pad_gpio_ib_mode_sel  output  NUM_IO each  per-channel pad controls.
REQ-015 pad_gpio_dm  output  3*NUM_IO  digital mode, channel i at [3i+2:3i].
REQ-016 pad_gpio_in  input  NUM_IO  pad inputs; sys_gpio_in  output  NUM_IO  pass-through.
REQ-017 pad_gpio_out/oeb/ieb  output  NUM_IO each; sys_gpio_out/oeb/ieb  input  NUM_IO each.

Function
REQ-018 SHALL hold NUM_IO x 12-bit shadow registers and NUM_IO x 12-bit active registers.
REQ-019 FSM states: IDLE, PEND, COMMIT; IDLE->PEND on cfg_commit with fabric_done=0; IDLE or PEND->COMMIT on cfg_commit with fabric_done=1, or in PEND when fabric_done=1; COMMIT->IDLE unconditionally after one cycle.
REQ-020 Bit layout: [11] out value, [10] oeb value, [9] ieb value, [8] out override, [7] oeb override, [6] ieb override, [5] slow_sel, [4] vtrip_sel, [3] ib_mode_sel, [2:0] dm.
REQ-021 wr_ready SHALL be 1 in IDLE and PEND and 0 in COMMIT.
REQ-022 A write is accepted when wr_valid and wr_ready are both high; shadow[wr_idx] updates at that edge.
REQ-023 A write with wr_idx >= NUM_IO SHALL be accepted and discarded, and SHALL set cfg_err until reset.
REQ-024 In COMMIT, active[i] <= shadow[i] for each i with FABRIC_MASK[i]=1; unmasked channels keep CFG_DEFAULTS.
REQ-025 A write accepted in the same cycle as cfg_commit SHALL be included in the commit.
REQ-026 Commit latency: cfg_commit sampled at edge N with fabric_done=1 -> active updated at edge N+1 -> cfg_applied high for the cycle after N+1.
REQ-027 cfg_commit asserted in PEND or COMMIT SHALL be absorbed, with no second copy queued.
REQ-028 When fabric_done is low, the effective config of every channel SHALL be CFG_DEFAULTS combinationally; active registers are retained, not cleared.
REQ-029 Per channel, pad_gpio_out = out override ? out value : sys_gpio_out; oeb and ieb use the same override scheme.
REQ-030 sys_gpio_in SHALL equal pad_gpio_in combinationally, with zero latency.

Reset
REQ-031 Asserting resetn low SHALL set shadow and active to CFG_DEFAULTS, FSM to IDLE, cfg_applied=0, cfg_err=0.
REQ-032 Reset SHALL take effect immediately, including mid-COMMIT; no partial copy SHALL survive.

Configuration
REQ-033 MPD_IO_CFG_READBACK_EN defined: adds ports rd_idx (input, wr_idx width) and rd_data (output, 12), where rd_data is the registered active[rd_idx] with 1-cycle latency, and 0 if rd_idx is out of range.
REQ-034 MPD_IO_CFG_READBACK_EN undefined: these ports and their logic SHALL be absent.

Structure
REQ-035 Shared package mpd_io_pkg SHALL hold the bit-index constants of REQ-020, the FSM state encoding and the 12-bit config width constant.
REQ-036 Per-channel override muxing SHALL be in sub-module mpd_io_pad_mux, instantiated NUM_IO times.

Verification
REQ-037 Reset release -> all pad_gpio_dm=3'b001; pad_gpio_out equals sys_gpio_out; cfg_err=0.
REQ-038 fabric_done=1; write idx 2 = 12'h907; commit -> cfg_applied pulses 2 cycles after the commit edge; channel 2 pad_gpio_out=1, dm=3'b111; other channels unchanged.
REQ-039 fabric_done=0, commit -> no cfg_applied; raise fabric_done 5 cycles later -> applied one cycle after the rise.
REQ-040 Write idx = NUM_IO -> cfg_err=1 and no shadow change; cfg_err stays 1 until reset.
REQ-041 FABRIC_MASK=8'hFE; write idx 0, commit -> channel 0 stays at CFG_DEFAULTS.
REQ-042 Write plus commit in the same cycle -> the new value is applied; resetn asserted in COMMIT -> all outputs return to defaults.

Source files
------------

// File: rtl/mpd_io_pkg.sv
// Shared constants for the pad configuration bank: config word
// bit positions, word width and commit FSM state encoding.
package mpd_io_pkg;

   localparam int CFG_W     = 12;
   localparam int DM_W      = 3;

   localparam int B_OUT_VAL = 11;
   localparam int B_OEB_VAL = 10;
   localparam int B_IEB_VAL = 9;
   localparam int B_OUT_OVR = 8;
   localparam int B_OEB_OVR = 7;
   localparam int B_IEB_OVR = 6;
   localparam int B_SLOW    = 5;
   localparam int B_VTRIP   = 4;
   localparam int B_IBMODE  = 3;
   localparam int B_DM_LSB  = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PEND   = 2'd1,
      ST_COMMIT = 2'd2
   } cfg_state_e;

   // Channel index width, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mpd_io_cfg_bank_if.sv
// Shadow-write / commit bus of the pad configuration bank.
// Master drives writes and commits; slave is the bank.
interface mpd_io_cfg_bank_if #(
   parameter int IW = 3
);
   import mpd_io_pkg::*;

   logic             wr_valid;
   logic             wr_ready;
   logic [IW-1:0]    wr_idx;
   logic [CFG_W-1:0] wr_data;
   logic             cfg_commit;
   logic             cfg_applied;
   logic             cfg_err;

   modport master (
      output wr_valid, wr_idx, wr_data, cfg_commit,
      input  wr_ready, cfg_applied, cfg_err
   );

   modport slave (
      input  wr_valid, wr_idx, wr_data, cfg_commit,
      output wr_ready, cfg_applied, cfg_err
   );

endinterface

// File: rtl/mpd_io_pad_mux.sv
// One pad channel: splits a config word into pad controls and
// applies the out/oeb/ieb override muxes.
module mpd_io_pad_mux
   import mpd_io_pkg::*;
(
   input  logic [CFG_W-1:0] cfg_i,
   input  logic             sys_out_i,
   input  logic             sys_oeb_i,
   input  logic             sys_ieb_i,
   output logic             pad_out_o,
   output logic             pad_oeb_o,
   output logic             pad_ieb_o,
   output logic             slow_o,
   output logic             vtrip_o,
   output logic             ib_mode_o,
   output logic [DM_W-1:0]  dm_o
);

   // Override bit selects the config value over the system value.
   always_comb begin
      pad_out_o = cfg_i[B_OUT_OVR] ? cfg_i[B_OUT_VAL] : sys_out_i;
      pad_oeb_o = cfg_i[B_OEB_OVR] ? cfg_i[B_OEB_VAL] : sys_oeb_i;
      pad_ieb_o = cfg_i[B_IEB_OVR] ? cfg_i[B_IEB_VAL] : sys_ieb_i;
      slow_o    = cfg_i[B_SLOW];
      vtrip_o   = cfg_i[B_VTRIP];
      ib_mode_o = cfg_i[B_IBMODE];
      dm_o      = cfg_i[B_DM_LSB +: DM_W];
   end

endmodule

// File: rtl/mpd_io_cfg_bank.sv
// Pad configuration bank: shadow/active registers, commit FSM.
// MPD_IO_CFG_READBACK_EN adds a registered active readback port.
module mpd_io_cfg_bank
   import mpd_io_pkg::*;
#(
   parameter int               NUM_IO       = 8,
   parameter logic [CFG_W-1:0] CFG_DEFAULTS = 12'h001,
   parameter logic [NUM_IO-1:0] FABRIC_MASK = '1
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   fabric_done,
   mpd_io_cfg_bank_if.slave       bus,
   output logic [NUM_IO-1:0]      pad_gpio_slow_sel,
   output logic [NUM_IO-1:0]      pad_gpio_vtrip_sel,
   output logic [NUM_IO-1:0]      pad_gpio_ib_mode_sel,
   output logic [3*NUM_IO-1:0]    pad_gpio_dm,
   input  logic [NUM_IO-1:0]      pad_gpio_in,
   output logic [NUM_IO-1:0]      sys_gpio_in,
   output logic [NUM_IO-1:0]      pad_gpio_out,
   output logic [NUM_IO-1:0]      pad_gpio_oeb,
   output logic [NUM_IO-1:0]      pad_gpio_ieb,
   input  logic [NUM_IO-1:0]      sys_gpio_out,
   input  logic [NUM_IO-1:0]      sys_gpio_oeb,
   input  logic [NUM_IO-1:0]      sys_gpio_ieb
`ifdef MPD_IO_CFG_READBACK_EN
   ,
   input  logic [idx_w(NUM_IO)-1:0] rd_idx,
   output logic [CFG_W-1:0]         rd_data
`endif
);

   localparam int IW = idx_w(NUM_IO);

   logic [CFG_W-1:0] shadow_q [NUM_IO];
   logic [CFG_W-1:0] shadow_d [NUM_IO];
   logic [CFG_W-1:0] active_q [NUM_IO];
   logic [CFG_W-1:0] active_d [NUM_IO];
   cfg_state_e       state_q, state_d;
   logic             applied_q, applied_d;
   logic             err_q, err_d;
   logic             wr_fire;
   logic             idx_ok;

   assign bus.wr_ready    = (state_q != ST_COMMIT);
   assign bus.cfg_applied = applied_q;
   assign bus.cfg_err     = err_q;
   assign wr_fire = bus.wr_valid && bus.wr_ready;
   assign idx_ok  = 32'(bus.wr_idx) < 32'(NUM_IO);
   assign sys_gpio_in = pad_gpio_in;

   // Commit FSM; commits seen outside IDLE are absorbed.
   always_comb begin
      state_d   = state_q;
      applied_d = (state_q == ST_COMMIT);
      err_d     = err_q | (wr_fire & ~idx_ok);
      unique case (state_q)
         ST_IDLE:
            if (bus.cfg_commit)
               state_d = fabric_done ? ST_COMMIT : ST_PEND;
         ST_PEND:
            if (fabric_done) state_d = ST_COMMIT;
         ST_COMMIT:
            state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   // Shadow takes accepted writes; active copies masked channels.
   always_comb begin
      for (int i = 0; i < NUM_IO; i++) begin
         shadow_d[i] = shadow_q[i];
         active_d[i] = active_q[i];
         if (wr_fire && bus.wr_idx == IW'(i))
            shadow_d[i] = bus.wr_data;
         if (state_q == ST_COMMIT && FABRIC_MASK[i])
            active_d[i] = shadow_q[i];
      end
   end

   // State registers; reset discards any in-flight commit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         applied_q <= 1'b0;
         err_q     <= 1'b0;
         for (int i = 0; i < NUM_IO; i++) begin
            shadow_q[i] <= CFG_DEFAULTS;
            active_q[i] <= CFG_DEFAULTS;
         end
      end else begin
         state_q   <= state_d;
         applied_q <= applied_d;
         err_q     <= err_d;
         for (int i = 0; i < NUM_IO; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_IO; g++) begin : g_ch
      logic [CFG_W-1:0] eff;
      // Until fabric is configured every channel runs on defaults.
      assign eff = fabric_done ? active_q[g] : CFG_DEFAULTS;
      mpd_io_pad_mux u_mux (
         .cfg_i     (eff),
         .sys_out_i (sys_gpio_out[g]),
         .sys_oeb_i (sys_gpio_oeb[g]),
         .sys_ieb_i (sys_gpio_ieb[g]),
         .pad_out_o (pad_gpio_out[g]),
         .pad_oeb_o (pad_gpio_oeb[g]),
         .pad_ieb_o (pad_gpio_ieb[g]),
         .slow_o    (pad_gpio_slow_sel[g]),
         .vtrip_o   (pad_gpio_vtrip_sel[g]),
         .ib_mode_o (pad_gpio_ib_mode_sel[g]),
         .dm_o      (pad_gpio_dm[3*g +: 3])
      );
   end

`ifdef MPD_IO_CFG_READBACK_EN
   logic [CFG_W-1:0] rd_q, rd_d;

   // Select active word; out-of-range index reads zero.
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NUM_IO; i++)
         if (rd_idx == IW'(i)) rd_d = active_q[i];
   end

   // One-cycle registered readback.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rd_q <= '0;
      else         rd_q <= rd_d;
   end

   assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_mpd_io_cfg_bank.sv
// Directed bench for mpd_io_cfg_bank: six pad channels,
// channel 0 held back from fabric reconfiguration.
module tb_mpd_io_cfg_bank;
   import mpd_io_pkg::*;

   localparam int         N    = 6;
   localparam logic [N-1:0] MASK = 6'h3E;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic fabric_done = 1'b0;
   logic [N-1:0]   slow, vtrip, ibm;
   logic [3*N-1:0] dm;
   logic [N-1:0]   p_in, s_in;
   logic [N-1:0]   p_out, p_oeb, p_ieb;
   logic [N-1:0]   s_out, s_oeb, s_ieb;

   int n_chk = 0;
   int n_fail = 0;

   mpd_io_cfg_bank_if #(.IW(3)) bus ();

   mpd_io_cfg_bank #(
      .NUM_IO       (N),
      .CFG_DEFAULTS (12'h001),
      .FABRIC_MASK  (MASK)
   ) dut (
      .clk                  (clk),
      .resetn               (resetn),
      .fabric_done          (fabric_done),
      .bus                  (bus.slave),
      .pad_gpio_slow_sel    (slow),
      .pad_gpio_vtrip_sel   (vtrip),
      .pad_gpio_ib_mode_sel (ibm),
      .pad_gpio_dm          (dm),
      .pad_gpio_in          (p_in),
      .sys_gpio_in          (s_in),
      .pad_gpio_out         (p_out),
      .pad_gpio_oeb         (p_oeb),
      .pad_gpio_ieb         (p_ieb),
      .sys_gpio_out         (s_out),
      .sys_gpio_oeb         (s_oeb),
      .sys_gpio_ieb         (s_ieb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  idx;
      logic [11:0] data;
      logic [5:0]  sys;
      logic [8:0]  exp;
   } vec_t;

   vec_t       vt [6];
   logic [2:0] exp_dm [N];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic logic [3*N-1:0] pack_dm();
      logic [3*N-1:0] r;
      for (int i = 0; i < N; i++) r[3*i +: 3] = exp_dm[i];
      return r;
   endfunction

   task automatic set_sys(input logic [5:0] s);
      s_out = s;
      s_oeb = ~s;
      s_ieb = s;
   endtask

   task automatic wr(input logic [2:0] i,
                     input logic [11:0] d);
      @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_idx   = i;
      bus.wr_data  = d;
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   // Commit (optionally with a same-cycle write); count
   // negedges from the commit edge until cfg_applied.
   task automatic commit_wait(input logic do_wr,
                              input logic [2:0] i,
                              input logic [11:0] d,
                              output int lat,
                              output logic rdy);
      @(negedge clk);
      bus.cfg_commit = 1'b1;
      bus.wr_valid   = do_wr;
      bus.wr_idx     = i;
      bus.wr_data    = d;
      lat = 0;
      rdy = 1'b1;
      do begin
         @(negedge clk);
         bus.cfg_commit = 1'b0;
         bus.wr_valid   = 1'b0;
         lat++;
         if (lat == 1) rdy = bus.wr_ready;
      end while (!bus.cfg_applied && lat < 20);
   endtask

   initial begin
      int   lat;
      logic rdy;
      logic seen;
      logic [8:0] act;

      vt[0] = '{3'd2, 12'h907, 6'h00, 9'b111_000_110};
      vt[1] = '{3'd3, 12'h6C5, 6'h08, 9'b101_000_111};
      vt[2] = '{3'd5, 12'h03A, 6'h20, 9'b010_111_101};
      vt[3] = '{3'd0, 12'hFFF, 6'h3F, 9'b001_000_101};
      vt[4] = '{3'd1, 12'h1C0, 6'h3F, 9'b000_000_000};
      vt[5] = '{3'd4, 12'h000, 6'h00, 9'b000_000_010};
      for (int i = 0; i < N; i++) exp_dm[i] = 3'b001;

      bus.wr_valid   = 1'b0;
      bus.wr_idx     = '0;
      bus.wr_data    = '0;
      bus.cfg_commit = 1'b0;
      set_sys(6'h2B);
      p_in = 6'h15;

      repeat (3) @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("rst_dm", 32'(dm), 32'(pack_dm()));
      chk("rst_out", 32'(p_out), 32'(s_out));
      chk("rst_oeb", 32'(p_oeb), 32'(s_oeb));
      chk("rst_err", 32'(bus.cfg_err), 32'd0);
      chk("rst_applied", 32'(bus.cfg_applied), 32'd0);
      chk("rst_ready", 32'(bus.wr_ready), 32'd1);
      chk("gpio_in", 32'(s_in), 32'h15);
      p_in = 6'h2A;
      #1;
      chk("gpio_in2", 32'(s_in), 32'h2A);

      @(negedge clk);
      fabric_done = 1'b1;
      #1;
      chk("fd_dm", 32'(dm), 32'(pack_dm()));

      for (int v = 0; v < 6; v++) begin
         set_sys(vt[v].sys);
         wr(vt[v].idx, vt[v].data);
         commit_wait(1'b0, 3'd0, 12'h0, lat, rdy);
         chk($sformatf("vec%0d_lat", v), 32'(lat), 32'd2);
         chk($sformatf("vec%0d_rdy", v), 32'(rdy), 32'd0);
         if (MASK[vt[v].idx])
            exp_dm[vt[v].idx] = vt[v].data[2:0];
         act = {dm[3*vt[v].idx +: 3], slow[vt[v].idx],
                vtrip[vt[v].idx], ibm[vt[v].idx],
                p_out[vt[v].idx], p_oeb[vt[v].idx],
                p_ieb[vt[v].idx]};
         chk($sformatf("vec%0d_pad", v), 32'(act),
             32'(vt[v].exp));
         chk($sformatf("vec%0d_all_dm", v), 32'(dm),
             32'(pack_dm()));
      end

      // fabric_done low: defaults everywhere, commit pends.
      @(negedge clk);
      fabric_done = 1'b0;
      #1;
      chk("fd0_dm", 32'(dm), 32'(18'o111111));
      wr(3'd4, 12'h005);
      @(negedge clk);
      bus.cfg_commit = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         bus.cfg_commit = (k == 2);
         if (bus.cfg_applied) seen = 1'b1;
      end
      chk("pend_no_apply", 32'(seen), 32'd0);
      fabric_done = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.cfg_applied && lat < 20);
      chk("pend_lat", 32'(lat), 32'd2);
      exp_dm[4] = 3'd5;
      chk("pend_dm", 32'(dm), 32'(pack_dm()));
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.cfg_applied) seen = 1'b1;
      end
      chk("no_second_copy", 32'(seen), 32'd0);

      // Out-of-range write: sticky error, no shadow change.
      wr(3'd6, 12'hABC);
      chk("err_set", 32'(bus.cfg_err), 32'd1);
      commit_wait(1'b0, 3'd0, 12'h0, lat, rdy);
      chk("err_dm", 32'(dm), 32'(pack_dm()));
      repeat (3) @(negedge clk);
      chk("err_sticky", 32'(bus.cfg_err), 32'd1);

      // Write in the same cycle as the commit is applied.
      commit_wait(1'b1, 3'd3, 12'h002, lat, rdy);
      chk("same_lat", 32'(lat), 32'd2);
      exp_dm[3] = 3'd2;
      chk("same_dm", 32'(dm), 32'(pack_dm()));

      // Reset during COMMIT: nothing survives.
      set_sys(6'h15);
      wr(3'd2, 12'h905);
      @(negedge clk);
      bus.cfg_commit = 1'b1;
      @(negedge clk);
      bus.cfg_commit = 1'b0;
      chk("commit_rdy", 32'(bus.wr_ready), 32'd0);
      resetn = 1'b0;
      #1;
      for (int i = 0; i < N; i++) exp_dm[i] = 3'b001;
      chk("rstc_dm", 32'(dm), 32'(pack_dm()));
      chk("rstc_out", 32'(p_out), 32'(s_out));
      chk("rstc_err", 32'(bus.cfg_err), 32'd0);
      chk("rstc_applied", 32'(bus.cfg_applied), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus.cfg_applied) seen = 1'b1;
      end
      chk("rstc_no_apply", 32'(seen), 32'd0);
      chk("rstc_dm2", 32'(dm), 32'(pack_dm()));
      commit_wait(1'b0, 3'd0, 12'h0, lat, rdy);
      chk("rstc_shadow", 32'(dm), 32'(pack_dm()));
      chk("rstc_out2", 32'(p_out), 32'(s_out));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
